// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: FSM encodings and default address map shared by the PC unit
package pc_unit_pkg;
  typedef enum logic [1:0] {
    PC_BOOT      = 2'd0,
    PC_RUN       = 2'd1,
    PC_ERET_WAIT = 2'd2
  } pc_state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] ISR_PC_DEF   = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned IM_BYTES_DEF = 16384;
endpackage

// File: rtl/pc_unit_fetch_adel_check.sv
// fetch_adel_check: flags misaligned or out-of-IM fetch addresses
module fetch_adel_check
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int unsigned IM_BYTES = IM_BYTES_DEF
) (
  input  logic [31:0] addr,
  output logic        adel
);
  localparam logic [31:0] IM_END = IM_BASE + IM_BYTES;
  assign adel = (|addr[1:0]) || (addr < IM_BASE) || (addr >= IM_END);
endmodule

// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with exception/ERET/stall arbitration.
// Define PC_UNIT_FETCH_ADEL_EN to generate the registered fetch_adel flag.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] ISR_PC   = ISR_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] next_pc,
  input  logic        branch_in_id,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        in_delay_slot,
  output logic        eret_pending,
  output logic        fetch_adel
);
  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d, epc_q, epc_d;
  logic        valid_q, valid_d, dly_q, dly_d, pend_q, pend_d;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    valid_d = valid_q;
    dly_d   = dly_q;
    pend_d  = pend_q;
    case (state_q)
      PC_BOOT: begin
        state_d = PC_RUN;
        valid_d = 1'b1;
      end
      PC_RUN: begin
        if (exc_req) begin
          pc_d    = ISR_PC;
          dly_d   = 1'b0;
          valid_d = 1'b1;
        end else if (eret_req && !stall) begin
          pc_d  = epc;
          dly_d = 1'b0;
        end else if (eret_req) begin
          epc_d   = epc;
          pend_d  = 1'b1;
          state_d = PC_ERET_WAIT;
        end else if (!stall) begin
          pc_d  = next_pc;
          dly_d = branch_in_id;
        end
      end
      PC_ERET_WAIT: begin
        if (exc_req || !stall) begin
          pc_d    = exc_req ? ISR_PC : epc_q;
          dly_d   = 1'b0;
          valid_d = 1'b1;
          pend_d  = 1'b0;
          state_d = PC_RUN;
        end
      end
      default: state_d = PC_BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PC_BOOT;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      valid_q <= 1'b0;
      dly_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      valid_q <= valid_d;
      dly_q   <= dly_d;
      pend_q  <= pend_d;
    end
  end
  assign pc            = pc_q;
  assign pc_valid      = valid_q;
  assign in_delay_slot = dly_q;
  assign eret_pending  = pend_q;
`ifdef PC_UNIT_FETCH_ADEL_EN
  // Checking pc_d keeps the flag in step with pc and naturally held on stall
  logic adel_d, adel_q;
  fetch_adel_check u_adel (
    .addr(pc_d),
    .adel(adel_d)
  );
  always_ff @(posedge clk) begin
    if (reset) adel_q <= 1'b0;
    else adel_q <= adel_d;
  end
  assign fetch_adel = adel_q;
`else
  assign fetch_adel = 1'b0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset, stall, branch_in_id, exc_req, eret_req;
  logic [31:0] next_pc, epc, pc;
  logic        pc_valid, in_delay_slot, eret_pending, fetch_adel;
  int checks = 0;
  int failures = 0;
`ifdef PC_UNIT_FETCH_ADEL_EN
  localparam logic ADEL_ON = 1'b1;
`else
  localparam logic ADEL_ON = 1'b0;
`endif

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .next_pc(next_pc),
    .branch_in_id(branch_in_id), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .pc(pc), .pc_valid(pc_valid), .in_delay_slot(in_delay_slot),
    .eret_pending(eret_pending), .fetch_adel(fetch_adel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_v,
                         input logic e_d, input logic e_p);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".valid"}, {31'b0, pc_valid}, {31'b0, e_v});
    chk({tag, ".dly"}, {31'b0, in_delay_slot}, {31'b0, e_d});
    chk({tag, ".pend"}, {31'b0, eret_pending}, {31'b0, e_p});
  endtask

  initial begin
    reset = 1; stall = 0; branch_in_id = 0; exc_req = 0; eret_req = 0;
    next_pc = 32'h3004; epc = 0;
    tick(); tick();
    chk_all("reset", 32'h3000, 0, 0, 0);
    chk("reset.adel", {31'b0, fetch_adel}, 0);
    reset = 0;
    tick();
    chk_all("boot", 32'h3000, 1, 0, 0);
    tick();
    chk_all("run1", 32'h3004, 1, 0, 0);
    branch_in_id = 1; next_pc = 32'h3010;
    tick();
    chk_all("branch", 32'h3010, 1, 1, 0);
    branch_in_id = 0; next_pc = 32'h3014;
    tick();
    chk_all("dslot_clr", 32'h3014, 1, 0, 0);
    branch_in_id = 1; next_pc = 32'h3020;
    tick();
    chk_all("branch2", 32'h3020, 1, 1, 0);
    stall = 1; branch_in_id = 0;
    next_pc = 32'h3100; tick(); chk_all("stall1", 32'h3020, 1, 1, 0);
    next_pc = 32'h3200; tick(); chk_all("stall2", 32'h3020, 1, 1, 0);
    next_pc = 32'h3300; tick(); chk_all("stall3", 32'h3020, 1, 1, 0);
    stall = 0; next_pc = 32'h3024;
    tick();
    chk_all("unstall", 32'h3024, 1, 0, 0);
    // ERET under stall, resolved by stall release
    stall = 1; eret_req = 1; epc = 32'h3040;
    tick();
    chk_all("eret_latch", 32'h3024, 1, 0, 1);
    eret_req = 0; epc = 32'h0; next_pc = 32'h3500; branch_in_id = 1;
    tick();
    chk_all("eret_wait", 32'h3024, 1, 0, 1);
    stall = 0;
    tick();
    chk_all("eret_done", 32'h3040, 1, 0, 0);
    // ERET under stall, preempted by exception
    branch_in_id = 0; stall = 1; eret_req = 1; epc = 32'h3080;
    tick();
    chk_all("eret_latch2", 32'h3040, 1, 0, 1);
    eret_req = 0; exc_req = 1;
    tick();
    chk_all("wait_exc", 32'h4180, 1, 0, 0);
    exc_req = 0;
    tick();
    chk_all("exc_hold", 32'h4180, 1, 0, 0);
    stall = 0; next_pc = 32'h4184;
    tick();
    chk_all("epc_dropped", 32'h4184, 1, 0, 0);
    eret_req = 1; epc = 32'h3050; branch_in_id = 1; next_pc = 32'h5000;
    tick();
    chk_all("eret_direct", 32'h3050, 1, 0, 0);
    eret_req = 0; next_pc = 32'h3060;
    tick();
    chk_all("branch3", 32'h3060, 1, 1, 0);
    stall = 1; exc_req = 1; eret_req = 1; epc = 32'h3070;
    tick();
    chk_all("exc_eret_stall", 32'h4180, 1, 0, 0);
    stall = 0; exc_req = 0; eret_req = 0; branch_in_id = 0;
    // fetch address error checks
    next_pc = 32'h3002; tick(); chk("adel_misalign", {31'b0, fetch_adel}, {31'b0, ADEL_ON});
    next_pc = 32'h7000; tick(); chk("adel_high", {31'b0, fetch_adel}, {31'b0, ADEL_ON});
    next_pc = 32'h3ffc; tick(); chk("adel_ok", {31'b0, fetch_adel}, 0);
    next_pc = 32'h6ffc; tick(); chk("adel_top_ok", {31'b0, fetch_adel}, 0);
    next_pc = 32'h2ffc; tick(); chk("adel_low", {31'b0, fetch_adel}, {31'b0, ADEL_ON});
    stall = 1; next_pc = 32'h3ffc;
    tick();
    chk("adel_hold", {31'b0, fetch_adel}, {31'b0, ADEL_ON});
    chk("adel_hold.pc", pc, 32'h2ffc);
    // reset while waiting on an ERET
    stall = 0; next_pc = 32'h3400;
    tick();
    stall = 1; eret_req = 1; epc = 32'h3040;
    tick();
    chk_all("eret_latch3", 32'h3400, 1, 0, 1);
    reset = 1;
    tick();
    chk_all("reset_wait", 32'h3000, 0, 0, 0);
    chk("reset_wait.adel", {31'b0, fetch_adel}, 0);
    reset = 0; stall = 0; eret_req = 0; next_pc = 32'h3004;
    tick();
    chk_all("reboot", 32'h3000, 1, 0, 0);
    tick();
    chk_all("rerun", 32'h3004, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
